// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write-to-read
// bypass and a per-register pending scoreboard for RAW hazard detection.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_s [NREGS];
  logic [NREGS-1:0]  pend_s;

  function automatic logic port_hit(input logic en,
                                    input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] b);
    return en && (a == b);
  endfunction

  for (genvar r = 0; r < NREGS; r++) begin : g_entry
    localparam logic [ADDR_W-1:0] R_ADDR = ADDR_W'(r);
    localparam bit HARD_ZERO = (ZERO_REG != 0) && (r == 0);

    logic [DATA_W-1:0] val_r;
    logic              pend_r;
    logic              wa_hit_s;
    logic              wb_hit_s;
    logic              rsv_hit_s;

    assign wa_hit_s  = port_hit(wa_en, wa_addr, R_ADDR);
    assign wb_hit_s  = port_hit(wb_en, wb_addr, R_ADDR);
    assign rsv_hit_s = port_hit(rsv_en, rsv_addr, R_ADDR);

    // Entry storage and pending bit; port B wins a write collision and a
    // reservation outranks a same-cycle writeback.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_r  <= {DATA_W{1'b0}};
        pend_r <= 1'b0;
      end else if (HARD_ZERO) begin
        val_r  <= {DATA_W{1'b0}};
        pend_r <= 1'b0;
      end else begin
        if (wb_hit_s) begin
          val_r <= wb_data;
        end else if (wa_hit_s) begin
          val_r <= wa_data;
        end else begin
          val_r <= val_r;
        end
        if (rsv_hit_s) begin
          pend_r <= 1'b1;
        end else if (wa_hit_s || wb_hit_s) begin
          pend_r <= 1'b0;
        end else begin
          pend_r <= pend_r;
        end
      end
    end

    assign mem_s[r]  = val_r;
    assign pend_s[r] = pend_r;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = rd_addr[i*ADDR_W +: ADDR_W];

    // Read mux: a bypassed in-flight producer also clears the busy flag.
    always_comb begin
      data_s = mem_s[addr_s];
      busy_s = pend_s[addr_s];
      if ((ZERO_REG != 0) && (addr_s == {ADDR_W{1'b0}})) begin
        data_s = {DATA_W{1'b0}};
        busy_s = 1'b0;
      end else if ((BYPASS != 0) && port_hit(wb_en, wb_addr, addr_s)) begin
        data_s = wb_data;
        busy_s = 1'b0;
      end else if ((BYPASS != 0) && port_hit(wa_en, wa_addr, addr_s)) begin
        data_s = wa_data;
        busy_s = 1'b0;
      end else begin
        data_s = mem_s[addr_s];
        busy_s = pend_s[addr_s];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_s;
    assign rd_busy[i]                  = busy_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one bypassing and one non-bypassing
// instance driven in parallel, checked by tables and a reference model.
`timescale 1ns/100ps
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr = 10'd0;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        wa_en = 1'b0, wb_en = 1'b0, rsv_en = 1'b0;
  logic [4:0]  wa_addr = 5'd0, wb_addr = 5'd0, rsv_addr = 5'd0;
  logic [31:0] wa_data = 32'd0, wb_data = 32'd0;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mdl_mem [32];
  logic        mdl_pend [32];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr));

  regfile_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr));

  typedef struct {
    logic wa_en; logic [4:0] wa_addr; logic [31:0] wa_data;
    logic wb_en; logic [4:0] wb_addr; logic [31:0] wb_data;
    logic rsv_en; logic [4:0] rsv_addr;
    logic [4:0] ra0; logic [4:0] ra1;
    logic [31:0] d0b; logic y0b; logic [31:0] d0n; logic y0n;
    logic [31:0] d1b; logic y1b; logic [31:0] d1n; logic y1n;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
      input logic wae, input logic [4:0] waa, input logic [31:0] wad,
      input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
      input logic rse, input logic [4:0] rsa,
      input logic [4:0] a0, input logic [4:0] a1,
      input logic [31:0] d0b, input logic y0b, input logic [31:0] d0n, input logic y0n,
      input logic [31:0] d1b, input logic y1b, input logic [31:0] d1n, input logic y1n);
    vec_t v;
    v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
    v.rsv_en = rse; v.rsv_addr = rsa; v.ra0 = a0; v.ra1 = a1;
    v.d0b = d0b; v.y0b = y0b; v.d0n = d0n; v.y0n = y0n;
    v.d1b = d1b; v.y1b = y1b; v.d1n = d1n; v.y1n = y1n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected read following the architectural rules, not the RTL structure.
  task automatic exp_read(input bit byp, input logic [4:0] a,
                          output logic [31:0] d, output logic y);
    if (a == 5'd0) begin
      d = 32'd0; y = 1'b0;
    end else if (byp && wb_en && wb_addr == a) begin
      d = wb_data; y = 1'b0;
    end else if (byp && wa_en && wa_addr == a) begin
      d = wa_data; y = 1'b0;
    end else begin
      d = rst_n ? mdl_mem[a] : 32'd0;
      y = rst_n ? mdl_pend[a] : 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0]  a;
    logic [31:0] ed;
    logic        ey;
    for (int i = 0; i < 2; i++) begin
      a = rd_addr[i*5 +: 5];
      exp_read(1'b1, a, ed, ey);
      chk({tag, "_byp_data"}, rd_data_b[i*32 +: 32], ed);
      chk({tag, "_byp_busy"}, {31'd0, rd_busy_b[i]}, {31'd0, ey});
      exp_read(1'b0, a, ed, ey);
      chk({tag, "_nob_data"}, rd_data_n[i*32 +: 32], ed);
      chk({tag, "_nob_busy"}, {31'd0, rd_busy_n[i]}, {31'd0, ey});
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mdl_mem[r] = 32'd0;
      mdl_pend[r] = 1'b0;
    end
  endtask

  // Edge behaviour: B wins collisions, reserve beats writeback, r0 immutable.
  task automatic model_update();
    if (wa_en && wa_addr != 5'd0) mdl_mem[wa_addr] = wa_data;
    if (wb_en && wb_addr != 5'd0) mdl_mem[wb_addr] = wb_data;
    if (wa_en && wa_addr != 5'd0) mdl_pend[wa_addr] = 1'b0;
    if (wb_en && wb_addr != 5'd0) mdl_pend[wb_addr] = 1'b0;
    if (rsv_en && rsv_addr != 5'd0) mdl_pend[rsv_addr] = 1'b1;
  endtask

  task automatic idle_inputs();
    wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    //        wa                wb               rsv     ra0 ra1  d0b          y0b d0n          y0n d1b          y1b d1n          y1n
    tbl[0]  = mk(1,5,32'h1111, 1,5,32'h2222,    0,0,   5,0, 32'h2222,0, 32'h0,0,     32'h0,0,     32'h0,0);
    tbl[1]  = mk(0,0,32'h0,    0,0,32'h0,       0,0,   5,5, 32'h2222,0, 32'h2222,0,  32'h2222,0,  32'h2222,0);
    tbl[2]  = mk(1,7,32'hDEADBEEF, 0,0,32'h0,   0,0,   7,5, 32'hDEADBEEF,0, 32'h0,0, 32'h2222,0,  32'h2222,0);
    tbl[3]  = mk(0,0,32'h0,    0,0,32'h0,       0,0,   7,7, 32'hDEADBEEF,0, 32'hDEADBEEF,0, 32'hDEADBEEF,0, 32'hDEADBEEF,0);
    tbl[4]  = mk(0,0,32'h0,    0,0,32'h0,       1,9,   9,7, 32'h0,0,    32'h0,0,     32'hDEADBEEF,0, 32'hDEADBEEF,0);
    tbl[5]  = mk(0,0,32'h0,    0,0,32'h0,       0,0,   9,9, 32'h0,1,    32'h0,1,     32'h0,1,     32'h0,1);
    tbl[6]  = mk(0,0,32'h0,    0,0,32'h0,       0,0,   9,5, 32'h0,1,    32'h0,1,     32'h2222,0,  32'h2222,0);
    tbl[7]  = mk(0,0,32'h0,    0,0,32'h0,       0,0,   9,9, 32'h0,1,    32'h0,1,     32'h0,1,     32'h0,1);
    tbl[8]  = mk(1,9,32'h42,   0,0,32'h0,       0,0,   9,9, 32'h42,0,   32'h0,1,     32'h42,0,    32'h0,1);
    tbl[9]  = mk(0,0,32'h0,    0,0,32'h0,       0,0,   9,7, 32'h42,0,   32'h42,0,    32'hDEADBEEF,0, 32'hDEADBEEF,0);
    tbl[10] = mk(0,0,32'h0,    1,9,32'h77,      1,9,   9,5, 32'h77,0,   32'h42,0,    32'h2222,0,  32'h2222,0);
    tbl[11] = mk(0,0,32'h0,    0,0,32'h0,       0,0,   9,9, 32'h77,1,   32'h77,1,    32'h77,1,    32'h77,1);
    tbl[12] = mk(1,0,32'hFFFFFFFF, 0,0,32'h0,   1,0,   0,0, 32'h0,0,    32'h0,0,     32'h0,0,     32'h0,0);
    tbl[13] = mk(0,0,32'h0,    0,0,32'h0,       0,0,   0,0, 32'h0,0,    32'h0,0,     32'h0,0,     32'h0,0);
    tbl[14] = mk(0,0,32'h0,    1,9,32'h55,      0,0,   9,0, 32'h55,0,   32'h77,1,    32'h0,0,     32'h0,0);
    tbl[15] = mk(0,0,32'h0,    0,0,32'h0,       0,0,   9,0, 32'h55,0,   32'h55,0,    32'h0,0,     32'h0,0);

    // Reset state
    @(posedge clk); #1;
    rd_addr = {5'd31, 5'd1};
    #1 check_all("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      wa_en = tbl[i].wa_en; wa_addr = tbl[i].wa_addr; wa_data = tbl[i].wa_data;
      wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
      rsv_en = tbl[i].rsv_en; rsv_addr = tbl[i].rsv_addr;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      @(negedge clk);
      chk($sformatf("tbl%0d_d0_byp", i), rd_data_b[31:0], tbl[i].d0b);
      chk($sformatf("tbl%0d_y0_byp", i), {31'd0, rd_busy_b[0]}, {31'd0, tbl[i].y0b});
      chk($sformatf("tbl%0d_d0_nob", i), rd_data_n[31:0], tbl[i].d0n);
      chk($sformatf("tbl%0d_y0_nob", i), {31'd0, rd_busy_n[0]}, {31'd0, tbl[i].y0n});
      chk($sformatf("tbl%0d_d1_byp", i), rd_data_b[63:32], tbl[i].d1b);
      chk($sformatf("tbl%0d_y1_byp", i), {31'd0, rd_busy_b[1]}, {31'd0, tbl[i].y1b});
      chk($sformatf("tbl%0d_d1_nob", i), rd_data_n[63:32], tbl[i].d1n);
      chk($sformatf("tbl%0d_y1_nob", i), {31'd0, rd_busy_n[1]}, {31'd0, tbl[i].y1n});
      @(posedge clk);
      model_update();
      #1;
    end
    idle_inputs();

    // Fill and reserve every register, then reset between edges
    for (int r = 1; r < 32; r++) begin
      wa_en = 1'b1; wa_addr = 5'(r); wa_data = 32'hA5A5_0000 + 32'(r);
      rsv_en = 1'b1; rsv_addr = 5'(r);
      rd_addr = {5'(r), 5'(r - 1)};
      step("fill");
    end
    idle_inputs();
    rd_addr = {5'd31, 5'd17};
    step("filled");
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 16; k++) begin
      rd_addr = {5'(2 * k + 1), 5'(2 * k)};
      #0.2;
      check_all("rst_sweep");
    end
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hFFFF_0003;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hFFFF_0004;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    @(posedge clk); #1;
    idle_inputs();
    rd_addr = {5'd4, 5'd3};
    #1 check_all("rst_ignore");
    @(posedge clk); #2;
    rst_n = 1'b1;
    step("post_rst");

    // Randomized traffic concentrated on a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      wa_en = 1'($urandom_range(0, 1)); wa_addr = 5'($urandom_range(0, 7)); wa_data = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      rsv_en = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 7));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
